// File: rtl/seq_multiplier_n_pkg.sv
// Shared constants for the sequential shift-add multiplier:
// controller state encodings and the iteration counter width.
package seq_multiplier_n_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_n_ctrl.sv
// Multiplier controller: IDLE/RUN/SIGN FSM, iteration counter,
// load/iterate/finish strobes and the ready/busy/done handshake.
module seq_mult_ctrl
  import seq_multiplier_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic ld,
  output logic run,
  output logic fin,
  output logic ready,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;
  logic             st_idle, st_run, st_sign;

  assign st_idle = (state_q == ST_IDLE);
  assign st_run  = (state_q == ST_RUN);
  assign st_sign = (state_q == ST_SIGN);

  // ready stays low in the done cycle so a held start
  // is only taken once the result has been presented
  assign ready = st_idle & ~done_q;
  assign busy  = st_run | st_sign;
  assign ld    = ready & start;
  assign run   = st_run & ~abort;
  assign fin   = st_sign & ~abort;
  assign done  = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      st_idle: begin
        if (ld) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      st_run: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = ST_SIGN;
        end
      end
      st_sign: begin
        state_d = ST_IDLE;
        if (abort) cnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= fin;
    end
  end

endmodule

// File: rtl/seq_multiplier_n.sv
// Sequential signed/unsigned shift-add multiplier: magnitude
// datapath with final negate, driven by seq_mult_ctrl.
module seq_multiplier_n
  import seq_multiplier_n_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               abort,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic ld, run, fin;

  seq_mult_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .ld    (ld),
    .run   (run),
    .fin   (fin),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0]   mcand_q, mag_a, mag_b;
  logic               neg_q, a_neg, b_neg;
  logic [WIDTH:0]     sum;

  assign a_neg = signed_mode & multiplicand[WIDTH-1];
  assign b_neg = signed_mode & multiplier[WIDTH-1];
  // -2^(W-1) maps onto itself, which is its correct unsigned magnitude
  assign mag_a = a_neg ? (~multiplicand + WIDTH'(1)) : multiplicand;
  assign mag_b = b_neg ? (~multiplier + WIDTH'(1)) : multiplier;

  always_comb begin
    sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
        + {1'b0, (prod_q[0] ? mcand_q : '0)};
    prod_d = {sum, prod_q[WIDTH-1:1]};
    res_d  = neg_q ? (~prod_q + 1'b1) : prod_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      if (ld) begin
        prod_q  <= {{WIDTH{1'b0}}, mag_b};
        mcand_q <= mag_a;
        neg_q   <= a_neg ^ b_neg;
      end else if (run) begin
        prod_q <= prod_d;
      end
      if (fin) res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: doc/seq_multiplier_n.md
Name: seq_multiplier_n

Overview:
Parametrised sequential shift-add multiplier with an integrated controller. It supports unsigned and two's-complement signed operands, selected per operation. A start/ready/done handshake replaces external shr/add/incr sequencing. The block sits in the ALU datapath as the next-generation multiply unit, and the ALU top drives it directly.

Parameters:
WIDTH, 32, operand width in bits (>=4); result is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
start  input  1  request; accepted only when ready=1.
signed_mode  input  1  1 = operands are two's complement; 0 = unsigned; sampled with start.
abort  input  1  synchronous cancel of an in-flight operation.
multiplicand  input  WIDTH  operand A; sampled with start.
multiplier  input  WIDTH  operand B; sampled with start.
ready  output  1  high in IDLE only.
busy  output  1  high in RUN and SIGN.
done  output  1  single-cycle pulse when result becomes valid.
result  output  2*WIDTH  product; holds until the next accepted start completes.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, product=0, counter=0, result=0, done=0, busy=0, ready=1.
  - Applies immediately, including mid-operation; no done is produced for a killed operation.
- States: IDLE, RUN, SIGN.
- IDLE:
  - On start=1, latch neg_flag and operands, then go to RUN.
  - signed_mode=1: neg_flag = A[MSB] xor B[MSB]; operands are replaced by their magnitudes (abs, WIDTH-bit unsigned).
  - signed_mode=0: neg_flag=0.
  - Entry values: product={WIDTH'b0, |B|}, mcand_reg=|A|, counter=0.
  - start=0 in IDLE: no state change.
- RUN (one iteration per cycle):
  - sum = product[2W-1:W] + (product[0] ? mcand_reg : 0), computed WIDTH+1 bits wide.
  - product <= {sum, product[W-1:1]}, i.e. shift right with the adder carry entering the MSB.
  - counter <= counter+1.
  - When counter == WIDTH-1 at the clock edge, go to SIGN. Exactly WIDTH RUN cycles.
- SIGN:
  - result <= neg_flag ? (~product + 1) : product; done=1 for this cycle only; next state IDLE.
- Latency: start sampled at edge 0; done high during the cycle following edge WIDTH+1 (WIDTH+2 cycles start-to-done); ready returns the cycle after done.
- Back-to-back: start may be asserted in the cycle ready rises.
- abort=1 while busy: next state IDLE, counter=0, result unchanged, no done. abort in IDLE is ignored. abort has priority over the SIGN->done transition.
- start while busy: ignored; operands are not re-sampled.
- Edge values:
  - Most-negative operand: magnitude 2^(W-1) fits unsigned W bits.
  - (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), representable.
  - A zero operand with neg_flag=1 yields 0 (negation of 0 = 0).
- No overflow output: the 2W-bit result is always exact.

Decomposition:
- Shared header: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_SIGN=2'd2) and the CNT_W derivation function.
- One natural sub-module, seq_mult_ctrl: FSM plus counter, producing ld/run/fin strobes. The datapath (abs, add-shift, negate) stays in seq_multiplier_n.

Test Plan:
- WIDTH=8, unsigned, A=8'hFF, B=8'hFF -> done 10 cycles after start, result=16'hFE01; ready low throughout.
- WIDTH=8, signed, A=8'h80 (-128), B=8'h80 -> result=16'h4000; A=8'h80, B=8'h01 -> result=16'hFF80.
- WIDTH=32, signed, A=-7, B=6 -> result=64'hFFFF_FFFF_FFFF_FFD6 after 34 cycles; unsigned 0 x 0xDEADBEEF -> 0.
- Back-to-back: start held high across the done cycle with new operands 3x5 (WIDTH=8, unsigned) -> second done exactly 10 cycles after re-acceptance, result=16'h000F; first result is held until then.
- abort at RUN iteration 3 -> ready next cycle, no done pulse, result keeps the prior value; start ignored while busy.
- rst driven low asynchronously mid-RUN (between clock edges) -> outputs go to reset values immediately; after release, a fresh 12x12 (WIDTH=8, unsigned) gives 16'h0090.
